vector_writeback_collector: RTL and testbench

//  Final writeback stage in front of the vector register file. Merges full-vector

---
 rtl/vector_writeback_collector_if.sv | 45 ++++
 rtl/vector_writeback_collector.sv | 151 +++++++++++++++
 tb/tb_vector_writeback_collector.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_writeback_collector_if.sv
// Bus bundle for the vector writeback collector: execute results, gather lanes, register-file write port.
// master = producer/consumer side (execute, memory, register file); slave = the collector.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

interface vector_writeback_collector_if #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 32
);
  localparam int VW = NUM_LANES * LANE_WIDTH;
  localparam int IW = $clog2(NUM_LANES);
  localparam int RW = `REG_IDX_WIDTH;

  logic                  ex_valid;
  logic [RW-1:0]         ex_reg;
  logic [VW-1:0]         ex_value;
  logic [NUM_LANES-1:0]  ex_mask;
  logic                  ga_start;
  logic [RW-1:0]         ga_reg;
  logic [NUM_LANES-1:0]  ga_mask;
  logic                  ga_lane_valid;
  logic [IW-1:0]         ga_lane_idx;
  logic [LANE_WIDTH-1:0] ga_lane_data;
  logic                  ga_ready;
  logic                  wb_enable_vector_writeback;
  logic [RW-1:0]         wb_writeback_reg;
  logic [VW-1:0]         wb_writeback_value;
  logic [NUM_LANES-1:0]  wb_writeback_mask;
  logic                  ga_error;

  modport master (
    output ex_valid, ex_reg, ex_value, ex_mask,
    output ga_start, ga_reg, ga_mask, ga_lane_valid, ga_lane_idx, ga_lane_data,
    input  ga_ready, wb_enable_vector_writeback, wb_writeback_reg,
    input  wb_writeback_value, wb_writeback_mask, ga_error
  );

  modport slave (
    input  ex_valid, ex_reg, ex_value, ex_mask,
    input  ga_start, ga_reg, ga_mask, ga_lane_valid, ga_lane_idx, ga_lane_data,
    output ga_ready, wb_enable_vector_writeback, wb_writeback_reg,
    output wb_writeback_value, wb_writeback_mask, ga_error
  );
endinterface

// File: rtl/vector_writeback_collector.sv
// Vector writeback stage: execute results take the write port first; gathered lanes are
// assembled into one masked write. Define VWB_LANE_CHECK_EN for sticky lane-protocol checking (ga_error).
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

// state   | meaning
// IDLE    | no gather open, ga_ready high
// COLLECT | gather open, accepting returned lanes
// PENDING | all lanes in, waiting for a cycle without an execute write
module vector_writeback_collector #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  vector_writeback_collector_if.slave     bus
);
  localparam int VW = NUM_LANES * LANE_WIDTH;
  localparam int RW = `REG_IDX_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, PENDING} state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        reg_q, reg_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [NUM_LANES-1:0] got_q, got_d;
  logic [VW-1:0]        data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 wb_en_q, wb_en_d;
  logic [RW-1:0]        wb_reg_q, wb_reg_d;
  logic [VW-1:0]        wb_val_q, wb_val_d;
  logic [NUM_LANES-1:0] wb_mask_q, wb_mask_d;
  logic [NUM_LANES-1:0] lane_bit;
  logic                 lane_ok;
  logic [VW-1:0]        gather_value;

  // Stray lanes may sit in the collector; they must never reach the register file.
  always_comb begin
    gather_value = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_q[i]) gather_value[i*LANE_WIDTH +: LANE_WIDTH] = data_q[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

`ifdef VWB_LANE_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    reg_d     = reg_q;
    mask_d    = mask_q;
    got_d     = got_q;
    data_d    = data_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_val_d  = wb_val_q;
    wb_mask_d = wb_mask_q;
    lane_bit  = NUM_LANES'(1) << bus.ga_lane_idx;
`ifdef VWB_LANE_CHECK_EN
    err_d   = err_q;
    lane_ok = (state_q == COLLECT) && ((lane_bit & mask_q) != '0) && ((lane_bit & got_q) == '0);
    if (bus.ga_lane_valid && !lane_ok) err_d = 1'b1;
    if (bus.ga_start && !ready_q) err_d = 1'b1;
`else
    lane_ok = (state_q == COLLECT);
`endif

    if (bus.ex_valid) begin
      wb_en_d   = 1'b1;
      wb_reg_d  = bus.ex_reg;
      wb_val_d  = bus.ex_value;
      wb_mask_d = bus.ex_mask;
    end

    case (state_q)
      IDLE: begin
        if (bus.ga_start && (bus.ga_mask != '0)) begin
          reg_d   = bus.ga_reg;
          mask_d  = bus.ga_mask;
          got_d   = '0;
          data_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.ga_lane_valid && lane_ok) begin
          data_d[bus.ga_lane_idx*LANE_WIDTH +: LANE_WIDTH] = bus.ga_lane_data;
          got_d = got_q | (lane_bit & mask_q);
          if (got_d == mask_q) state_d = PENDING;
        end
      end
      PENDING: begin
        if (!bus.ex_valid) begin
          wb_en_d   = 1'b1;
          wb_reg_d  = reg_q;
          wb_val_d  = gather_value;
          wb_mask_d = mask_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      reg_q     <= '0;
      mask_q    <= '0;
      got_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_val_q  <= '0;
      wb_mask_q <= '0;
`ifdef VWB_LANE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      mask_q    <= mask_d;
      got_q     <= got_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_val_q  <= wb_val_d;
      wb_mask_q <= wb_mask_d;
`ifdef VWB_LANE_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.ga_ready                   = ready_q;
  assign bus.wb_enable_vector_writeback = wb_en_q;
  assign bus.wb_writeback_reg           = wb_reg_q;
  assign bus.wb_writeback_value         = wb_val_q;
  assign bus.wb_writeback_mask          = wb_mask_q;
`ifdef VWB_LANE_CHECK_EN
  assign bus.ga_error = err_q;
`else
  assign bus.ga_error = 1'b0;
`endif
endmodule

// File: tb/tb_vector_writeback_collector.sv
// Directed bench for vector_writeback_collector: transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module tb_vector_writeback_collector;
  localparam int NL = 16;
  localparam int LW = 32;
  localparam int VW = NL * LW;
  localparam int RW = `REG_IDX_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vector_writeback_collector_if #(.NUM_LANES(NL), .LANE_WIDTH(LW)) bus ();
  vector_writeback_collector #(.NUM_LANES(NL), .LANE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an open gather is a set of expected lanes; a finished gather queues one write
  // that goes out on the first cycle the execute side leaves the port free.
  bit            m_open = 0, m_full = 0;
  logic [RW-1:0] m_reg = '0;
  logic [NL-1:0] m_mask = '0, m_got = '0;
  logic [LW-1:0] m_lane [NL];
  logic          e_en = 0, e_ready = 1, e_err = 0;
  logic [RW-1:0] e_reg = '0;
  logic [VW-1:0] e_val = '0;
  logic [NL-1:0] e_mask = '0;

  function automatic logic [VW-1:0] gather_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) if (m_mask[i]) v[i*LW +: LW] = m_lane[i];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_open = 0; m_full = 0; m_reg = '0; m_mask = '0; m_got = '0;
      for (int i = 0; i < NL; i++) m_lane[i] = '0;
      e_en = 0; e_reg = '0; e_val = '0; e_mask = '0; e_ready = 1; e_err = 0;
    end else begin
      e_en = 0;
      if (bus.ex_valid) begin
        e_en = 1; e_reg = bus.ex_reg; e_val = bus.ex_value; e_mask = bus.ex_mask;
      end else if (m_full) begin
        e_en = 1; e_reg = m_reg; e_val = gather_vec(); e_mask = m_mask; m_full = 0;
      end
      if (bus.ga_lane_valid) begin
`ifdef VWB_LANE_CHECK_EN
        if (m_open && m_mask[bus.ga_lane_idx] && !m_got[bus.ga_lane_idx]) begin
          m_lane[bus.ga_lane_idx] = bus.ga_lane_data;
          m_got[bus.ga_lane_idx] = 1'b1;
        end else e_err = 1;
`else
        if (m_open) begin
          m_lane[bus.ga_lane_idx] = bus.ga_lane_data;
          if (m_mask[bus.ga_lane_idx]) m_got[bus.ga_lane_idx] = 1'b1;
        end
`endif
      end
      if (m_open && (m_got == m_mask)) begin
        m_open = 0; m_full = 1;
      end
`ifdef VWB_LANE_CHECK_EN
      if (bus.ga_start && !e_ready) e_err = 1;
`endif
      if (bus.ga_start && e_ready && (bus.ga_mask != '0)) begin
        m_open = 1; m_reg = bus.ga_reg; m_mask = bus.ga_mask; m_got = '0;
        for (int i = 0; i < NL; i++) m_lane[i] = '0;
      end
      e_ready = !m_open && !m_full;
    end
  end

  always @(negedge clk) begin
    chk("cmp_enable", VW'(bus.wb_enable_vector_writeback), VW'(e_en));
    chk("cmp_reg", VW'(bus.wb_writeback_reg), VW'(e_reg));
    chk("cmp_value", bus.wb_writeback_value, e_val);
    chk("cmp_mask", VW'(bus.wb_writeback_mask), VW'(e_mask));
    chk("cmp_ready", VW'(bus.ga_ready), VW'(e_ready));
    chk("cmp_error", VW'(bus.ga_error), VW'(e_err));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.ex_reg = '0; bus.ex_value = '0; bus.ex_mask = '0;
    bus.ga_start = 0; bus.ga_reg = '0; bus.ga_mask = '0;
    bus.ga_lane_valid = 0; bus.ga_lane_idx = '0; bus.ga_lane_data = '0;
  endtask

  task automatic start_gather(input logic [RW-1:0] r, input logic [NL-1:0] m);
    bus.ga_start = 1; bus.ga_reg = r; bus.ga_mask = m;
    cyc();
    bus.ga_start = 0;
  endtask

  task automatic send_lane(input logic [3:0] idx, input logic [LW-1:0] d);
    bus.ga_lane_valid = 1; bus.ga_lane_idx = idx; bus.ga_lane_data = d;
    cyc();
    bus.ga_lane_valid = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic chk_ex_write(input string name, input logic [RW-1:0] r,
                              input logic [VW-1:0] v, input logic [NL-1:0] m);
    chk({name, "_en"}, VW'(bus.wb_enable_vector_writeback), VW'(1'b1));
    chk({name, "_reg"}, VW'(bus.wb_writeback_reg), VW'(r));
    chk({name, "_val"}, bus.wb_writeback_value, v);
    chk({name, "_mask"}, VW'(bus.wb_writeback_mask), VW'(m));
  endtask

  logic [VW-1:0] vec, gvec, seven;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < NL; i++) m_lane[i] = '0;
    #12;
    chk("reset_en", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    chk("reset_value", bus.wb_writeback_value, '0);
    chk("reset_ready", VW'(bus.ga_ready), VW'(1'b1));
    chk("reset_error", VW'(bus.ga_error), VW'(1'b0));
    @(posedge clk); #1;
    reset = 0;
    cyc();

    // 1: execute write, strobe for exactly one cycle, values held afterwards
    vec = '0;
    for (int i = 0; i < NL; i++) vec[i*LW +: LW] = LW'(i);
    bus.ex_valid = 1; bus.ex_reg = 5; bus.ex_value = vec; bus.ex_mask = 16'hFFFF;
    cyc();
    bus.ex_valid = 0;
    chk_ex_write("t1", 5, vec, 16'hFFFF);
    cyc();
    chk("t1_en_low", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    chk("t1_reg_hold", VW'(bus.wb_writeback_reg), VW'(5));

    // empty execute mask still strobes
    bus.ex_valid = 1; bus.ex_reg = 2; bus.ex_value = 512'hABC; bus.ex_mask = '0;
    cyc();
    bus.ex_valid = 0;
    chk_ex_write("t1b", 2, 512'hABC, 16'h0000);
    cyc();

    // 2: two-lane gather, out of order
    gvec = '0;
    gvec[15*LW +: LW] = 32'hDEAD;
    gvec[0 +: LW] = 32'hBEEF;
    start_gather(3, 16'h8001);
    chk("t2_ready_low", VW'(bus.ga_ready), VW'(1'b0));
    send_lane(15, 32'hDEAD);
    send_lane(0, 32'hBEEF);
    chk("t2_no_early_strobe", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    cyc();
    chk_ex_write("t2", 3, gvec, 16'h8001);
    chk("t2_ready_high", VW'(bus.ga_ready), VW'(1'b1));
    cyc();

    // 3: execute holds the port three cycles while the gather is pending
    seven = {16{32'h7}};
    start_gather(3, 16'h8001);
    send_lane(15, 32'hDEAD);
    send_lane(0, 32'hBEEF);
    bus.ex_valid = 1; bus.ex_reg = 7; bus.ex_value = seven; bus.ex_mask = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_ex_write("t3_ex", 7, seven, 16'hFFFF);
    end
    bus.ex_valid = 0;
    cyc();
    chk_ex_write("t3_ga", 3, gvec, 16'h8001);
    cyc();
    chk("t3_en_low", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));

    // 4: empty gather mask, then reset in the middle of a gather
    start_gather(1, 16'h0000);
    chk("t4_empty_ready", VW'(bus.ga_ready), VW'(1'b1));
    chk("t4_empty_no_strobe", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    start_gather(9, 16'h0011);
    send_lane(0, 32'h1234);
    reset = 1;
    #1;
    chk("t4_rst_reg", VW'(bus.wb_writeback_reg), '0);
    chk("t4_rst_value", bus.wb_writeback_value, '0);
    chk("t4_rst_mask", VW'(bus.wb_writeback_mask), '0);
    chk("t4_rst_ready", VW'(bus.ga_ready), VW'(1'b1));
    cyc();
    reset = 0;
    send_lane(4, 32'h5678);
    for (int k = 0; k < 3; k++) cyc();
    chk("t4_no_write", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    chk("t4_ready", VW'(bus.ga_ready), VW'(1'b1));

    pulse_reset();
    gvec = '0;
    gvec[0 +: LW] = 32'h11;
    gvec[LW +: LW] = 32'h20;
`ifdef VWB_LANE_CHECK_EN
    // 5: stray lane raises a sticky error and is dropped
    start_gather(6, 16'h0003);
    chk("t5_err_before", VW'(bus.ga_error), VW'(1'b0));
    send_lane(4, 32'h44);
    chk("t5_err_set", VW'(bus.ga_error), VW'(1'b1));
    send_lane(0, 32'h11);
    send_lane(1, 32'h20);
    cyc();
    chk_ex_write("t5", 6, gvec, 16'h0003);
    cyc();
    chk("t5_err_sticky", VW'(bus.ga_error), VW'(1'b1));
`else
    // stray and duplicate lanes are stored but never complete or leak into the write
    start_gather(6, 16'h0003);
    send_lane(4, 32'h44);
    bus.ga_start = 1; bus.ga_reg = 1; bus.ga_mask = 16'hFFFF;
    send_lane(0, 32'h10);
    bus.ga_start = 0;
    send_lane(0, 32'h11);
    cyc();
    chk("t5_no_complete", VW'(bus.wb_enable_vector_writeback), VW'(1'b0));
    chk("t5_busy", VW'(bus.ga_ready), VW'(1'b0));
    send_lane(1, 32'h20);
    cyc();
    chk_ex_write("t5", 6, gvec, 16'h0003);
    chk("t5_no_error", VW'(bus.ga_error), VW'(1'b0));
`endif
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
